// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX operand-select stage.
package id_ex_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_SLT = 2'b11;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // A bubble is the all-zero value of this record.
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [REG_W-1:0]  rs_idx;
    logic [REG_W-1:0]  rt_idx;
    logic [REG_W-1:0]  wr_idx;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] imm;
    logic              alu_src;
    logic [1:0]        alu_op;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              ovf_en;
  } ex_reg_t;

  function automatic logic [DATA_W-1:0] ext_imm(input logic [15:0] imm,
                                                input logic        sext);
    return {{16{sext & imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding select: EX/MEM result over MEM/WB result over the stored value.
module fwd_mux
  import id_ex_stage_pkg::*;
(
  input  logic [REG_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] raw_i,
  input  logic              mem_wr_i,
  input  logic [REG_W-1:0]  mem_idx_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              wb_wr_i,
  input  logic [REG_W-1:0]  wb_idx_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic [DATA_W-1:0] data_o
);

  logic hit_mem;
  logic hit_wb;

  assign hit_mem = mem_wr_i && (mem_idx_i == idx_i) && (idx_i != REG_ZERO);
  assign hit_wb  = wb_wr_i  && (wb_idx_i  == idx_i) && (idx_i != REG_ZERO);

  always_comb begin
    data_o = raw_i;
    if (hit_mem)     data_o = mem_data_i;
    else if (hit_wb) data_o = wb_data_i;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, immediate select and
// load-use hazard detection feeding the ALU.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [REG_W-1:0]  id_rs_idx,
  input  logic [REG_W-1:0]  id_rt_idx,
  input  logic [REG_W-1:0]  id_wr_idx,
  input  logic [DATA_W-1:0] id_rs_val,
  input  logic [DATA_W-1:0] id_rt_val,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [15:0]       id_imm,
  input  logic              id_imm_sext,
  input  logic              id_alu_src,
  input  logic [1:0]        id_alu_op,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_ovf_en,
  input  logic              fwd_mem_wr,
  input  logic [REG_W-1:0]  fwd_mem_idx,
  input  logic [DATA_W-1:0] fwd_mem_data,
  input  logic              fwd_wb_wr,
  input  logic [REG_W-1:0]  fwd_wb_idx,
  input  logic [DATA_W-1:0] fwd_wb_data,
  input  logic              ex_stall,
  input  logic              ex_flush,
  output logic              hazard_stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [REG_W-1:0]  ex_wr_idx,
  output logic [1:0]        ex_alu_op,
  output logic [DATA_W-1:0] ex_data1,
  output logic [DATA_W-1:0] ex_data2,
  output logic [DATA_W-1:0] ex_rt_fwd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_ovf_en
);

  ex_reg_t ex_q, ex_d, id_cap;
  logic    rs_hit_wb, rt_hit_wb;
  logic    rs_dep, rt_dep;
  logic [DATA_W-1:0] rs_fwd, rt_fwd;

  // A producer retiring from WB this cycle is not yet visible in the
  // register-file read data, so patch it in at capture.
  assign rs_hit_wb = fwd_wb_wr && (fwd_wb_idx == id_rs_idx) && (id_rs_idx != REG_ZERO);
  assign rt_hit_wb = fwd_wb_wr && (fwd_wb_idx == id_rt_idx) && (id_rt_idx != REG_ZERO);

  always_comb begin
    id_cap           = '0;
    id_cap.valid     = id_valid;
    id_cap.pc        = id_pc;
    id_cap.rs_idx    = id_rs_idx;
    id_cap.rt_idx    = id_rt_idx;
    id_cap.wr_idx    = id_wr_idx;
    id_cap.rs_val    = rs_hit_wb ? fwd_wb_data : id_rs_val;
    id_cap.rt_val    = rt_hit_wb ? fwd_wb_data : id_rt_val;
    id_cap.imm       = ext_imm(id_imm, id_imm_sext);
    id_cap.alu_src   = id_alu_src;
    id_cap.alu_op    = id_alu_op;
    id_cap.reg_write = id_reg_write;
    id_cap.mem_read  = id_mem_read;
    id_cap.mem_write = id_mem_write;
    id_cap.ovf_en    = id_ovf_en;
  end

  assign rs_dep = id_uses_rs && (id_rs_idx == ex_q.wr_idx);
  assign rt_dep = id_uses_rt && (id_rt_idx == ex_q.wr_idx);

  assign hazard_stall = ex_q.valid && ex_q.mem_read && (ex_q.wr_idx != REG_ZERO) &&
                        id_valid && (rs_dep || rt_dep) && !ex_flush;

  always_comb begin
    ex_d = ex_q;
    if (ex_flush)          ex_d = '0;
    else if (ex_stall)     ex_d = ex_q;
    else if (hazard_stall) ex_d = '0;
    else                   ex_d = id_cap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  fwd_mux u_fwd_rs (
    .idx_i      (ex_q.rs_idx),
    .raw_i      (ex_q.rs_val),
    .mem_wr_i   (fwd_mem_wr),
    .mem_idx_i  (fwd_mem_idx),
    .mem_data_i (fwd_mem_data),
    .wb_wr_i    (fwd_wb_wr),
    .wb_idx_i   (fwd_wb_idx),
    .wb_data_i  (fwd_wb_data),
    .data_o     (rs_fwd)
  );

  fwd_mux u_fwd_rt (
    .idx_i      (ex_q.rt_idx),
    .raw_i      (ex_q.rt_val),
    .mem_wr_i   (fwd_mem_wr),
    .mem_idx_i  (fwd_mem_idx),
    .mem_data_i (fwd_mem_data),
    .wb_wr_i    (fwd_wb_wr),
    .wb_idx_i   (fwd_wb_idx),
    .wb_data_i  (fwd_wb_data),
    .data_o     (rt_fwd)
  );

  assign ex_valid     = ex_q.valid;
  assign ex_pc        = ex_q.pc;
  assign ex_wr_idx    = ex_q.wr_idx;
  assign ex_alu_op    = ex_q.alu_op;
  assign ex_data1     = rs_fwd;
  assign ex_data2     = ex_q.alu_src ? ex_q.imm : rt_fwd;
  assign ex_rt_fwd    = rt_fwd;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_ovf_en    = ex_q.ovf_en;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and operand-select stage that sits directly upstream of the ALU. Captures decoded instructions from ID and holds them for EX. Resolves register operands by forwarding from EX/MEM and MEM/WB, selects the immediate or rt for the ALU's second operand, and detects load-use hazards, inserting one bubble per hazard. Its outputs drive the ALU's `data1`/`data2`/`alu_op` inputs directly and carry the remaining control fields on to EX/MEM.

## Interface
- No parameters. Data width is fixed at 32 and register index width at 5.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `id_valid`  in  1  ID holds a real instruction
- `id_pc`  in  32  instruction PC
- `id_rs_idx`, `id_rt_idx`, `id_wr_idx`  in  5 each  source and destination register indices
- `id_rs_val`, `id_rt_val`  in  32 each  register-file read data
- `id_uses_rs`, `id_uses_rt`  in  1 each  instruction reads rs / rt
- `id_imm`  in  16  raw immediate
- `id_imm_sext`  in  1  1 = sign-extend, 0 = zero-extend
- `id_alu_src`  in  1  1 = `data2` takes the immediate
- `id_alu_op`  in  2  ALU operation (ADD/SUB/OR/SLT)
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_ovf_en`  in  1 each  downstream control
- `fwd_mem_wr`, `fwd_mem_idx[4:0]`, `fwd_mem_data[31:0]`  in  EX/MEM result. `fwd_mem_wr` is low for loads.
- `fwd_wb_wr`, `fwd_wb_idx[4:0]`, `fwd_wb_data[31:0]`  in  MEM/WB result
- `ex_stall`  in  1  back-end freeze
- `ex_flush`  in  1  kill the instruction entering EX
- `hazard_stall`  out  1  load-use hazard; IF/ID must hold
- `ex_valid`, `ex_pc[31:0]`, `ex_wr_idx[4:0]`, `ex_alu_op[1:0]`  out  registered fields
- `ex_data1`, `ex_data2`, `ex_rt_fwd`  out  32 each  forwarded operands. `ex_rt_fwd` is the store data.
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_ovf_en`  out  1 each

## Operation
- **Register update.** Each rising edge updates the register by priority: `ex_flush` > `ex_stall` > `hazard_stall` > capture.
  - Flush or hazard: load a bubble.
  - Stall: hold all registers.
  - Capture: load all `id_*` fields.
- **Bubble.** `ex_valid=0` and `reg_write`/`mem_read`/`mem_write`/`ovf_en` are forced to 0. Data fields are don't-care but are driven to 0.
- **Capture-time bypass.** If `fwd_wb_wr` is set, `fwd_wb_idx` matches the index, and the index is not 0, the stored rs/rt raw value is `fwd_wb_data` instead of `id_*_val`. This covers a producer that retires while its consumer is in ID.
- **Immediate.** Extended to 32 bits at capture according to `id_imm_sext`. Examples: 0x8000 sign-extends to 0xFFFF8000 and zero-extends to 0x00008000.
- **EX forwarding.** Combinational, applied to the registered rs and rt values.
  - Index 0 never forwards.
  - Priority is `fwd_mem` over `fwd_wb` over the stored raw value.
  - `ex_data1` = fwd(rs).
  - `ex_rt_fwd` = fwd(rt).
  - `ex_data2` = `alu_src` ? extended immediate : fwd(rt).
- **Load-use hazard.** `hazard_stall` = `ex_valid` & `ex_mem_read` & (`ex_wr_idx`≠0) & `id_valid` & ((`id_uses_rs` & rs==`ex_wr_idx`) | (`id_uses_rt` & rt==`ex_wr_idx`)) & ~`ex_flush`. It is combinational and independent of `ex_stall`.
- **Sources under stall.** `ex_stall` freezes EX/MEM and MEM/WB as well, so forwarding sources are stable while this stage is held.

## Timing
- Capture latency is 1 cycle. Outputs are valid immediately after the edge plus the combinational forwarding mux delay.
- A load-use hazard costs exactly one bubble. On the next edge the load moves to MEM and the hazard clears.
- `ex_flush` and `ex_stall` asserted in the same cycle produce a bubble on the next edge.
- Reset: `rst_n` low clears every registered output to 0 immediately (asynchronously), so `ex_valid=0` and all enables are 0. `hazard_stall` then reads 0. Deassertion mid-stream restarts capture on the first edge.

## Structure
- Shared package holds:
  - ALU op constants: `ALU_ADD`=2'b00, `ALU_SUB`=2'b01, `ALU_OR`=2'b10, `ALU_SLT`=2'b11.
  - `REG_ZERO`=5'd0.
- One sub-module, `fwd_mux`, implements the zero-check and the MEM > WB > raw priority select. It is instantiated twice, for rs and rt.

## Test plan
- **Plain capture.** ADD with rs=5 (val 7) and rt=6 (val 9), no forwarding → next cycle `ex_data1`=7, `ex_data2`=9, `ex_valid`=1, `ex_alu_op`=00.
- **Forward priority.** EX holds rs=5; `fwd_mem`(idx 5, 0x11) and `fwd_wb`(idx 5, 0x22) both active → `ex_data1`=0x11. Drop `fwd_mem` → 0x22. Repeat with rs=0 → raw value, no forwarding.
- **Load-use.** EX holds LW to r8; ID has ADD reading r8 → `hazard_stall`=1 that cycle. Next cycle `ex_valid`=0 and `ex_reg_write`=0. The following cycle ADD enters with its operand taken from `fwd_mem`/`fwd_wb`.
- **Immediate.** `id_imm`=0x8000 with `sext`=1, `alu_src`=1 → `ex_data2`=0xFFFF8000. With `sext`=0 (ORI) → 0x00008000. `ex_rt_fwd` still carries rt.
- **Stall and flush.** `ex_stall` held for 3 cycles → outputs constant across them. Assert `ex_flush` together with `ex_stall` → `ex_valid`=0 after the edge.
- **Reset and capture bypass.**
  - `rst_n` pulled low between edges mid-stream → all outputs are 0 before the next edge.
  - `fwd_wb`(idx 3, 0xABCD) active at capture of rs=3 with stale `id_rs_val` → `ex_data1`=0xABCD.
